// File: rtl/digit_window_capture.sv
// ============================================================================
// digit_window_capture : snapshot a decimated 28x28 VGA window into a buffer
// and stream it out row-major through a read_enable/read_valid handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module digit_window_capture #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int X0      = 306,
  parameter int Y0      = 226,
  parameter int SCALE   = 1,
  parameter int INVERT  = 0
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic [7:0] vga_data,
  input  logic       vga_valid,
  input  logic       vga_sof,
  input  logic       right_click,
  input  logic       read_enable,
  output logic [7:0] read_data,
  output logic       read_valid,
  output logic       capture_done,
  output logic       busy
);

  localparam int C_DEPTH = IMG_W * IMG_H;
  localparam int C_AW    = $clog2(C_DEPTH);
  localparam int C_CW    = $clog2(FRAME_W + 1);
  localparam int C_RW    = $clog2(FRAME_H + 1);
  localparam int C_SH    = $clog2(SCALE);
  localparam logic [C_AW-1:0] C_LAST = C_AW'(C_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READY   = 2'd3
  } state_t;

  state_t            r_state;
  logic [C_CW-1:0]   r_col;
  logic [C_RW-1:0]   r_row;
  logic [C_AW-1:0]   r_rd_ptr;
  logic              r_click_d;
  logic [7:0]        r_read_data;
  logic              r_read_valid;
  logic              r_capture_done;
  logic [7:0]        r_mem [C_DEPTH];

  logic [C_CW-1:0]   w_col;
  logic [C_RW-1:0]   w_row;
  logic [C_CW-1:0]   w_dx;
  logic [C_RW-1:0]   w_dy;
  logic              w_hit;
  logic [C_AW-1:0]   w_addr;
  logic [7:0]        w_pix;
  logic              w_we;
  logic              w_rd;

  // The sof pixel is (0,0) regardless of where the counters currently are.
  assign w_col = vga_sof ? '0 : r_col;
  assign w_row = vga_sof ? '0 : r_row;
  assign w_dx  = w_col - C_CW'(X0);
  assign w_dy  = w_row - C_RW'(Y0);

  assign w_hit = (w_col >= C_CW'(X0)) && (w_col < C_CW'(X0 + IMG_W * SCALE)) &&
                 (w_row >= C_RW'(Y0)) && (w_row < C_RW'(Y0 + IMG_H * SCALE)) &&
                 ((w_dx & C_CW'(SCALE - 1)) == '0) &&
                 ((w_dy & C_RW'(SCALE - 1)) == '0);

  assign w_addr = C_AW'(w_dy >> C_SH) * C_AW'(IMG_W) + C_AW'(w_dx >> C_SH);
  assign w_pix  = (INVERT != 0) ? (8'd255 - vga_data) : vga_data;
  assign w_we   = vga_valid && w_hit &&
                  ((r_state == S_CAPTURE) || ((r_state == S_ARMED) && vga_sof));
  assign w_rd   = (r_state == S_READY) && read_enable;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_pix;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (vga_valid) begin
      if (vga_sof) begin
        r_col <= C_CW'(1);
        r_row <= '0;
      end else if (r_row != C_RW'(FRAME_H)) begin
        if (r_col == C_CW'(FRAME_W - 1)) begin
          r_col <= '0;
          r_row <= r_row + C_RW'(1);
        end else begin
          r_col <= r_col + C_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= S_IDLE;
      r_rd_ptr       <= '0;
      r_click_d      <= 1'b0;
      r_read_data    <= 8'd0;
      r_read_valid   <= 1'b0;
      r_capture_done <= 1'b0;
    end else begin
      r_click_d    <= right_click;
      r_read_valid <= w_rd;
      if (w_rd) r_read_data <= r_mem[r_rd_ptr];
      case (r_state)
        S_IDLE: begin
          if (right_click && !r_click_d) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (w_we && (w_addr == C_LAST)) begin
            r_state        <= S_READY;
            r_capture_done <= 1'b1;
            r_rd_ptr       <= '0;
          end else if (vga_valid && vga_sof) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // A new sof simply rewrites from address 0; no extra bookkeeping.
          if (w_we && (w_addr == C_LAST)) begin
            r_state        <= S_READY;
            r_capture_done <= 1'b1;
            r_rd_ptr       <= '0;
          end
        end
        S_READY: begin
          if (read_enable) begin
            if (r_rd_ptr == C_LAST) begin
              r_state        <= S_IDLE;
              r_capture_done <= 1'b0;
              r_rd_ptr       <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_data    = r_read_data;
  assign read_valid   = r_read_valid;
  assign capture_done = r_capture_done;
  assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire
